// File: rtl/primitive_assembler_if.sv
// primitive_assembler_if: vertex-stage input and rasterizer output bundle of the primitive assembler.
`ifndef OPCODE_WIDTH
`define OPCODE_WIDTH 8
`endif
`ifndef VREG_WIDTH
`define VREG_WIDTH 64
`endif
interface primitive_assembler_if;
  logic                     I_LOCK;
  logic [`OPCODE_WIDTH-1:0] I_Opcode;
  logic [`VREG_WIDTH-1:0]   I_VIn;
  logic [`VREG_WIDTH-1:0]   I_ColorIn;
  logic                     O_FRAMESTALL;
  logic                     O_TriValid;
  logic                     I_TriReady;
  logic [95:0]              O_TriVerts;
  logic [`VREG_WIDTH-1:0]   O_TriColor;
  logic [15:0]              O_TriCount;
  logic [7:0]               O_DropCount;
  modport master (
    output I_LOCK, I_Opcode, I_VIn, I_ColorIn, I_TriReady,
    input  O_FRAMESTALL, O_TriValid, O_TriVerts, O_TriColor, O_TriCount, O_DropCount
  );
  modport slave (
    input  I_LOCK, I_Opcode, I_VIn, I_ColorIn, I_TriReady,
    output O_FRAMESTALL, O_TriValid, O_TriVerts, O_TriColor, O_TriCount, O_DropCount
  );
endinterface

// File: rtl/primitive_assembler.sv
// primitive_assembler: collects vertex triples into flat-colored triangles behind a 2-deep output FIFO.
`ifndef OPCODE_WIDTH
`define OPCODE_WIDTH 8
`endif
`ifndef VREG_WIDTH
`define VREG_WIDTH 64
`endif
module primitive_assembler (
  input logic I_CLOCK,
  input logic I_RESET_N,
  primitive_assembler_if.slave bus
);
  localparam logic [`OPCODE_WIDTH-1:0] OP_BEGIN  = 'h01;
  localparam logic [`OPCODE_WIDTH-1:0] OP_END    = 'h02;
  localparam logic [`OPCODE_WIDTH-1:0] OP_VERTEX = 'h03;
  localparam logic [`OPCODE_WIDTH-1:0] OP_COLOR  = 'h04;
  typedef enum logic {IDLE, COLLECT} state_t;
  state_t state, state_nx;
  logic [1:0] vcount, count;
  logic head;
  logic [31:0] slot0, slot1, nv;
  logic [`VREG_WIDTH-1:0] color;
  logic [95:0] ent_v [2];
  logic [`VREG_WIDTH-1:0] ent_c [2];
  logic [15:0] tri_count;
  logic [7:0] drop_count;
  logic accept, is_vtx, push, pop, flush;
  logic unused_vin;
  assign unused_vin = ^{bus.I_VIn[`VREG_WIDTH-1:48], bus.I_VIn[15:0]};
  assign nv = {bus.I_VIn[47:32], bus.I_VIn[31:16]};
  assign accept = bus.I_LOCK && count != 2'd2;
  assign is_vtx = accept && bus.I_Opcode == OP_VERTEX && state == COLLECT;
  assign push = is_vtx && vcount == 2'd2;
  assign flush = accept && (bus.I_Opcode == OP_BEGIN || bus.I_Opcode == OP_END);
  assign pop = count != 2'd0 && bus.I_TriReady;
  assign bus.O_FRAMESTALL = count == 2'd2;
  assign bus.O_TriValid = count != 2'd0;
  assign bus.O_TriVerts = ent_v[head];
  assign bus.O_TriColor = ent_c[head];
  assign bus.O_TriCount = tri_count;
  assign bus.O_DropCount = drop_count;
  always_comb begin
    state_nx = state;
    if (accept)
      state_nx = bus.I_Opcode == OP_BEGIN ? COLLECT : bus.I_Opcode == OP_END ? IDLE : state;
  end
  always_ff @(negedge I_CLOCK or negedge I_RESET_N)
    if (!I_RESET_N) state <= IDLE;
    else state <= state_nx;
  always_ff @(negedge I_CLOCK or negedge I_RESET_N)
    if (!I_RESET_N) begin
      vcount <= '0;
      count <= '0;
      head <= 1'b0;
      slot0 <= '0;
      slot1 <= '0;
      color <= '0;
      ent_v[0] <= '0;
      ent_v[1] <= '0;
      ent_c[0] <= '0;
      ent_c[1] <= '0;
      tri_count <= '0;
      drop_count <= '0;
    end else begin
      if (flush) begin
        vcount <= '0;
        if (vcount != 2'd0 && drop_count != 8'hFF) drop_count <= drop_count + 8'd1;
      end else if (is_vtx) begin
        vcount <= push ? 2'd0 : vcount + 2'd1;
        if (vcount == 2'd0) slot0 <= nv;
        if (vcount == 2'd1) slot1 <= nv;
      end
      if (accept && bus.I_Opcode == OP_COLOR) color <= bus.I_ColorIn;
      // tail slot is head+count; a same-edge pop then promotes it to head
      if (push) begin
        ent_v[head ^ count[0]] <= {nv, slot1, slot0};
        ent_c[head ^ count[0]] <= color;
      end
      if (pop) begin
        head <= !head;
        tri_count <= tri_count + 16'd1;
      end
      count <= count + 2'(push) - 2'(pop);
    end
endmodule

// File: tb/tb_primitive_assembler.sv
// tb_primitive_assembler: directed stimulus with a triangle scoreboard checked by an output monitor.
`ifndef OPCODE_WIDTH
`define OPCODE_WIDTH 8
`endif
`ifndef VREG_WIDTH
`define VREG_WIDTH 64
`endif
module tb_primitive_assembler;
  localparam logic [`OPCODE_WIDTH-1:0] OP_NOP    = 'h00;
  localparam logic [`OPCODE_WIDTH-1:0] OP_BEGIN  = 'h01;
  localparam logic [`OPCODE_WIDTH-1:0] OP_END    = 'h02;
  localparam logic [`OPCODE_WIDTH-1:0] OP_VERTEX = 'h03;
  localparam logic [`OPCODE_WIDTH-1:0] OP_COLOR  = 'h04;
  typedef struct {
    logic [95:0] v;
    logic [`VREG_WIDTH-1:0] c;
  } tri_t;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int tests = 0;
  int fails = 0;
  tri_t sb [$];
  bit m_col = 0;
  int m_vc = 0;
  logic [31:0] m_s0 = '0, m_s1 = '0;
  logic [`VREG_WIDTH-1:0] m_color = '0;
  primitive_assembler_if bus ();
  primitive_assembler dut (.I_CLOCK(clk), .I_RESET_N(rst_n), .bus(bus));
  always #5 clk = ~clk;
  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask
  task automatic issue(input logic [`OPCODE_WIDTH-1:0] op, input logic [`VREG_WIDTH-1:0] v,
                       input logic [`VREG_WIDTH-1:0] c);
    int n = 0;
    bus.I_LOCK = 1'b1;
    bus.I_Opcode = op;
    bus.I_VIn = v;
    bus.I_ColorIn = c;
    @(posedge clk);
    while (bus.O_FRAMESTALL && n < 200) begin
      @(posedge clk);
      n++;
    end
    if (n >= 200) chk("issue_timeout", 128'(n), 128'd0);
    @(negedge clk);
    #1;
    bus.I_LOCK = 1'b0;
    bus.I_Opcode = OP_NOP;
    case (op)
      OP_BEGIN: begin m_col = 1; m_vc = 0; end
      OP_END: begin m_col = 0; m_vc = 0; end
      OP_COLOR: m_color = c;
      OP_VERTEX:
        if (m_col) begin
          if (m_vc == 2) begin
            sb.push_back('{v: {v[47:16], m_s1, m_s0}, c: m_color});
            m_vc = 0;
          end else begin
            if (m_vc == 0) m_s0 = v[47:16];
            else m_s1 = v[47:16];
            m_vc++;
          end
        end
      default: ;
    endcase
  endtask
  task automatic vtx(input logic [15:0] x, input logic [15:0] y);
    issue(OP_VERTEX, {16'h0, y, x, 16'h0}, '0);
  endtask
  task automatic drain();
    int n = 0;
    while ((sb.size() != 0 || bus.O_TriValid) && n < 100) begin
      @(negedge clk);
      n++;
    end
    #1;
    chk("drain", 128'(sb.size()), 128'd0);
  endtask
  always @(posedge clk)
    if (rst_n && bus.O_TriValid && bus.I_TriReady) begin
      if (sb.size() == 0) chk("unexpected_tri", 128'(bus.O_TriVerts), 128'd0);
      else begin
        tri_t e;
        e = sb.pop_front();
        chk("tri_verts", 128'(bus.O_TriVerts), 128'(e.v));
        chk("tri_color", 128'(bus.O_TriColor), 128'(e.c));
      end
    end
  initial begin
    bus.I_LOCK = 1'b0;
    bus.I_Opcode = OP_NOP;
    bus.I_VIn = '0;
    bus.I_ColorIn = '0;
    bus.I_TriReady = 1'b0;
    #1;
    chk("rst_valid", 128'(bus.O_TriValid), 128'd0);
    chk("rst_stall", 128'(bus.O_FRAMESTALL), 128'd0);
    chk("rst_verts", 128'(bus.O_TriVerts), 128'd0);
    chk("rst_color", 128'(bus.O_TriColor), 128'd0);
    chk("rst_tricount", 128'(bus.O_TriCount), 128'd0);
    chk("rst_dropcount", 128'(bus.O_DropCount), 128'd0);
    #21 rst_n = 1'b1;
    @(negedge clk);
    #1;
    // single triangle, visible one edge after its third vertex
    bus.I_TriReady = 1'b1;
    issue(OP_COLOR, '0, 64'h00FF);
    issue(OP_BEGIN, '0, '0);
    vtx(1, 2);
    vtx(3, 4);
    chk("valid_before_third", 128'(bus.O_TriValid), 128'd0);
    vtx(5, 6);
    chk("valid_after_third", 128'(bus.O_TriValid), 128'd1);
    chk("verts_first", 128'(bus.O_TriVerts), 128'h0006_0005_0004_0003_0002_0001);
    drain();
    chk("tricount_1", 128'(bus.O_TriCount), 128'd1);
    // FIFO fills, stalls, then drains in order
    bus.I_TriReady = 1'b0;
    issue(OP_COLOR, '0, 64'hABCD);
    issue(OP_BEGIN, '0, '0);
    for (int i = 0; i < 6; i++) vtx(16'(10 + i), 16'(100 + i));
    chk("stall_full", 128'(bus.O_FRAMESTALL), 128'd1);
    fork
      for (int i = 6; i < 9; i++) vtx(16'(10 + i), 16'(100 + i));
      begin
        repeat (5) @(negedge clk);
        #2;
        chk("stall_held", 128'(bus.O_FRAMESTALL), 128'd1);
        chk("tricount_held", 128'(bus.O_TriCount), 128'd1);
        bus.I_TriReady = 1'b1;
      end
    join
    drain();
    chk("tricount_4", 128'(bus.O_TriCount), 128'd4);
    chk("stall_clear", 128'(bus.O_FRAMESTALL), 128'd0);
    // BEGIN with one pending vertex is a drop
    issue(OP_BEGIN, '0, '0);
    vtx(7, 7);
    issue(OP_BEGIN, '0, '0);
    chk("drop_begin", 128'(bus.O_DropCount), 128'd1);
    for (int i = 0; i < 300; i++) begin
      issue(OP_BEGIN, '0, '0);
      vtx(1, 1);
      vtx(2, 2);
      issue(OP_END, '0, '0);
      if (i == 0) begin
        chk("drop_end", 128'(bus.O_DropCount), 128'd2);
        chk("drop_no_valid", 128'(bus.O_TriValid), 128'd0);
      end
    end
    chk("drop_saturate", 128'(bus.O_DropCount), 128'd255);
    // vertex in IDLE is ignored
    vtx(99, 99);
    issue(OP_BEGIN, '0, '0);
    vtx(20, 21);
    vtx(22, 23);
    vtx(24, 25);
    drain();
    chk("tricount_5", 128'(bus.O_TriCount), 128'd5);
    // unlocked vertex opcodes are ignored
    issue(OP_COLOR, '0, 64'h1234_5678);
    issue(OP_BEGIN, '0, '0);
    vtx(30, 31);
    bus.I_Opcode = OP_VERTEX;
    bus.I_VIn = {16'h0, 16'd77, 16'd77, 16'h0};
    repeat (3) @(negedge clk);
    #1;
    vtx(32, 33);
    vtx(34, 35);
    drain();
    chk("tricount_6", 128'(bus.O_TriCount), 128'd6);
    // asynchronous reset with one triangle queued and a partial primitive
    bus.I_TriReady = 1'b0;
    issue(OP_BEGIN, '0, '0);
    vtx(40, 41);
    vtx(42, 43);
    vtx(44, 45);
    vtx(46, 47);
    chk("pre_rst_valid", 128'(bus.O_TriValid), 128'd1);
    #3 rst_n = 1'b0;
    sb.delete();
    #1;
    chk("mid_rst_valid", 128'(bus.O_TriValid), 128'd0);
    chk("mid_rst_stall", 128'(bus.O_FRAMESTALL), 128'd0);
    chk("mid_rst_tricount", 128'(bus.O_TriCount), 128'd0);
    chk("mid_rst_dropcount", 128'(bus.O_DropCount), 128'd0);
    chk("mid_rst_verts", 128'(bus.O_TriVerts), 128'd0);
    @(posedge clk);
    rst_n = 1'b1;
    m_col = 0;
    m_vc = 0;
    m_color = '0;
    @(negedge clk);
    #1;
    bus.I_TriReady = 1'b1;
    issue(OP_BEGIN, '0, '0);
    vtx(1, 1);
    vtx(2, 2);
    vtx(3, 3);
    drain();
    chk("post_rst_tricount", 128'(bus.O_TriCount), 128'd1);
    chk("post_rst_dropcount", 128'(bus.O_DropCount), 128'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
